module_button_reader: RTL and testbench
=======================================

# module_button_reader

Input-side companion to the LED counter path. Reads N active-low board push-buttons, synchronizes them into the `clk` domain, debounces each one independently, and emits a clean level plus single-cycle press, release and long-press events. Downstream control logic consumes these events, for example to step, clear or pause the LED counter.

## Interface
- `N_BTN`, default 2: number of buttons, ≥1.
- `STABLE_CYCLES`, default 270000: consecutive cycles a changed input must hold before it is accepted (10 ms at 27 MHz), ≥1.
- `LONG_CYCLES`, default 27000000: cycles a debounced press must be held to raise a long-press event (1 s at 27 MHz), ≥1.

Ports:
- `clk` input 1: single system clock; all logic is on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `btn_n` input N_BTN: raw button pins, active-low (0 = pressed), asynchronous to `clk`.
- `level_o` output N_BTN: debounced state, active-high (1 = pressed).
- `press_o` output N_BTN: one-cycle pulse when `level_o[i]` goes 0→1.
- `release_o` output N_BTN: one-cycle pulse when `level_o[i]` goes 1→0.
- `long_o` output N_BTN: one-cycle pulse, at most once per press, after a long hold.

## Operation
- Per button `i`, fully independent; no cross-button interaction.
- Input path: `btn_n[i]` is inverted, then passes through a 2-FF synchronizer (`s1`, `s2`). Both flops reset to 0 (released), so reset never creates a spurious press.
- Debounce counter `dcnt`, width `$clog2(STABLE_CYCLES)` (minimum 1):
  - If `s2 == level`, then `dcnt <= 0`.
  - Else if `dcnt == STABLE_CYCLES-1`, then `level <= s2`, `dcnt <= 0`, and `press_o` or `release_o` is asserted on the same edge.
  - Else `dcnt <= dcnt + 1`.
  - Any glitch back to the current `level` restarts the count from 0.
- Per-button state machine:
  - UP: `level = 0`.
  - DOWN: `level = 1`, hold counter `hcnt` running.
  - HELD: `level = 1`, long event already issued.
  - UP→DOWN on accepted press, with `hcnt <= 0`.
  - DOWN: `hcnt` increments each cycle. When `hcnt == LONG_CYCLES-1`, pulse `long_o` and go to HELD.
  - DOWN or HELD → UP on accepted release. `hcnt` clears.
- `hcnt` width is `$clog2(LONG_CYCLES)` (minimum 1). It never wraps because it stops in HELD.
- A release accepted on the same edge that `hcnt` hits terminal: release wins, no `long_o`.
- All outputs are registered. Pulses are exactly one cycle wide and never overlap for the same button, except the release-wins case above.

## Timing
- Reset values (asynchronous, immediate):
  - `level_o`, `press_o`, `release_o`, `long_o` = 0.
  - All counters = 0; state = UP; `s1`/`s2` = 0.
- Reset deasserted mid-press: the block restarts in UP and re-debounces the held button. `press_o` fires `STABLE_CYCLES+2` edges after reset release if the button is still held.
- Latency:
  - The pin changes and is stable before edge E.
  - `s2` updates at E+1.
  - `level_o` and the event pulse update at edge E+1+`STABLE_CYCLES`.
- Long press: `long_o` fires `LONG_CYCLES` edges after the edge that asserted `press_o`.
- Minimum accepted pulse width: `STABLE_CYCLES` cycles at `s2`. Shorter bounces are invisible on every output.
- Throughput: one transition per button per `STABLE_CYCLES` cycles at most.

## Test plan
All scenarios use `N_BTN`=2, `STABLE_CYCLES`=4, `LONG_CYCLES`=20.
- **Reset:** assert `rst` with `btn_n`=2'b00 (both pressed).
  - All outputs are 0 throughout reset.
  - After release, `press_o`=2'b11 for exactly one cycle at edge 6, then `level_o`=2'b11.
- **Clean press/release:** drive `btn_n[0]` 1→0 before edge E and hold for 30 cycles, then release.
  - `press_o[0]` pulses at E+5.
  - `long_o[0]` pulses at E+25.
  - `release_o[0]` pulses 5 edges after the release.
  - `btn_n[1]` outputs stay 0.
- **Bounce rejection:** toggle `btn_n[0]` low for 3 cycles, high 1, low 3, high.
  - No pulse on any output; `level_o` stays 0.
  - Then hold low for 4 cycles: exactly one `press_o[0]`.
- **Short press:** hold low for 10 cycles, then release.
  - `press_o` and `release_o` each fire once.
  - No `long_o`.
- **Release/long collision:** time the release so it is accepted on the edge `hcnt` reaches 19.
  - `release_o` fires; `long_o` stays 0.
- **Independence and mid-operation reset:**
  - Press both buttons 2 cycles apart: their pulses are 2 cycles apart.
  - Assert `rst` while in HELD: all outputs drop to 0 immediately, and no `release_o` is emitted.

Source files
------------

// File: rtl/module_button_reader.sv
//==============================================================================
// Module      : module_button_reader
// Description : N-button reader: 2-FF sync, per-button debounce, clean level
//               plus one-cycle press / release / long-press event pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module module_button_reader #(
    parameter int N_BTN         = 2,
    parameter int STABLE_CYCLES = 270000,
    parameter int LONG_CYCLES   = 27000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] level_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] long_o
);

    localparam int c_DW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int c_HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [c_DW-1:0] c_DLAST = c_DW'(STABLE_CYCLES - 1);
    localparam logic [c_HW-1:0] c_HLAST = c_HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_UP   = 2'd0,
        ST_DOWN = 2'd1,
        ST_HELD = 2'd2
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            logic            r_s1;
            logic            r_s2;
            logic            r_level;
            logic            r_press;
            logic            r_rel;
            logic            r_long;
            logic [c_DW-1:0] r_dcnt;
            logic [c_HW-1:0] r_hcnt;
            state_t          r_state;
            logic            w_accept;
            logic            w_acc_press;
            logic            w_acc_rel;

            assign w_accept    = (r_s2 != r_level) && (r_dcnt == c_DLAST);
            assign w_acc_press = w_accept && r_s2;
            assign w_acc_rel   = w_accept && !r_s2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s1    <= 1'b0;
                    r_s2    <= 1'b0;
                    r_level <= 1'b0;
                    r_press <= 1'b0;
                    r_rel   <= 1'b0;
                    r_long  <= 1'b0;
                    r_dcnt  <= '0;
                    r_hcnt  <= '0;
                    r_state <= ST_UP;
                end else begin
                    r_s1    <= ~btn_n[gi];
                    r_s2    <= r_s1;
                    r_press <= 1'b0;
                    r_rel   <= 1'b0;
                    r_long  <= 1'b0;

                    // Any sample matching the accepted level restarts the count.
                    if (r_s2 == r_level) begin
                        r_dcnt <= '0;
                    end else if (r_dcnt == c_DLAST) begin
                        r_level <= r_s2;
                        r_dcnt  <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end

                    case (r_state)
                        ST_UP: begin
                            if (w_acc_press) begin
                                r_state <= ST_DOWN;
                                r_hcnt  <= '0;
                                r_press <= 1'b1;
                            end
                        end
                        ST_DOWN: begin
                            // Release takes priority over a simultaneous long hit.
                            if (w_acc_rel) begin
                                r_state <= ST_UP;
                                r_hcnt  <= '0;
                                r_rel   <= 1'b1;
                            end else if (r_hcnt == c_HLAST) begin
                                r_state <= ST_HELD;
                                r_long  <= 1'b1;
                            end else begin
                                r_hcnt <= r_hcnt + 1'b1;
                            end
                        end
                        ST_HELD: begin
                            if (w_acc_rel) begin
                                r_state <= ST_UP;
                                r_hcnt  <= '0;
                                r_rel   <= 1'b1;
                            end
                        end
                        default: begin
                            r_state <= ST_UP;
                            r_hcnt  <= '0;
                        end
                    endcase
                end
            end

            assign level_o[gi]   = r_level;
            assign press_o[gi]   = r_press;
            assign release_o[gi] = r_rel;
            assign long_o[gi]    = r_long;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_module_button_reader.sv
//==============================================================================
// Module      : tb_module_button_reader
// Description : Directed self-checking bench for module_button_reader.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_module_button_reader;

    localparam int c_N = 2;

    logic           clk;
    logic           rst;
    logic [c_N-1:0] btn_n;
    logic [c_N-1:0] level_o;
    logic [c_N-1:0] press_o;
    logic [c_N-1:0] release_o;
    logic [c_N-1:0] long_o;

    int checks;
    int passed;
    int cyc;
    int np[c_N], nr[c_N], nl[c_N], nlev[c_N];
    int tp[c_N], tr[c_N], tl[c_N];
    int overlap;

    module_button_reader #(
        .N_BTN        (c_N),
        .STABLE_CYCLES(4),
        .LONG_CYCLES  (20)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .btn_n    (btn_n),
        .level_o  (level_o),
        .press_o  (press_o),
        .release_o(release_o),
        .long_o   (long_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr_stats();
        cyc     = 0;
        overlap = 0;
        for (int i = 0; i < c_N; i++) begin
            np[i] = 0; nr[i] = 0; nl[i] = 0; nlev[i] = 0;
            tp[i] = -1; tr[i] = -1; tl[i] = -1;
        end
    endtask

    // One clock edge; outputs sampled 1 time unit after it and tallied.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < c_N; i++) begin
            if (press_o[i])   begin np[i]++; tp[i] = cyc; end
            if (release_o[i]) begin nr[i]++; tr[i] = cyc; end
            if (long_o[i])    begin nl[i]++; tl[i] = cyc; end
            if (level_o[i])   nlev[i]++;
            if (press_o[i] && (release_o[i] || long_o[i])) overlap++;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else passed++;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        btn_n = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({level_o, press_o, release_o, long_o} !== 8'h00)
                $display("FAIL reset_outputs: got %h expected 00",
                         {level_o, press_o, release_o, long_o});
            else passed++;
        end
        rst = 1'b0;
        clr_stats();
        run(6);
        checks++;
        if (press_o !== 2'b11) $display("FAIL reset_press_edge6: got %b expected 11", press_o);
        else passed++;
        checks++;
        if (np[0] !== 1 || np[1] !== 1 || tp[0] !== 6)
            $display("FAIL reset_press_once: got np0=%0d np1=%0d tp0=%0d expected 1 1 6", np[0], np[1], tp[0]);
        else passed++;
        tick();
        checks++;
        if (level_o !== 2'b11 || press_o !== 2'b00)
            $display("FAIL reset_level: got lvl=%b press=%b expected 11 00", level_o, press_o);
        else passed++;
        btn_n = 2'b11;
        run(15);
    endtask

    task automatic test_clean();
        clr_stats();
        btn_n = 2'b10;
        run(30);
        btn_n = 2'b11;
        run(10);
        chk("clean_press_cnt", np[0], 1);
        chk("clean_press_time", tp[0], 6);
        chk("clean_long_cnt", nl[0], 1);
        chk("clean_long_time", tl[0], 26);
        chk("clean_rel_cnt", nr[0], 1);
        chk("clean_rel_time", tr[0], 36);
        chk("clean_btn1_quiet", np[1] + nr[1] + nl[1] + nlev[1], 0);
        chk("clean_level_end", int'(level_o[0]), 0);
    endtask

    task automatic test_bounce();
        clr_stats();
        btn_n[0] = 1'b0; run(3);
        btn_n[0] = 1'b1; run(1);
        btn_n[0] = 1'b0; run(3);
        btn_n[0] = 1'b1; run(8);
        chk("bounce_no_events", np[0] + nr[0] + nl[0], 0);
        chk("bounce_no_level", nlev[0], 0);
        clr_stats();
        btn_n[0] = 1'b0; run(4);
        btn_n[0] = 1'b1; run(15);
        chk("bounce_min_press", np[0], 1);
        chk("bounce_min_release", nr[0], 1);
    endtask

    task automatic test_short();
        clr_stats();
        btn_n[0] = 1'b0; run(10);
        btn_n[0] = 1'b1; run(20);
        chk("short_press_time", tp[0], 6);
        chk("short_rel_time", tr[0], 16);
        chk("short_counts", np[0] * 100 + nr[0] * 10 + nl[0], 110);
    endtask

    task automatic test_collision();
        clr_stats();
        btn_n[0] = 1'b0; run(20);
        btn_n[0] = 1'b1; run(15);
        chk("collide_rel_time", tr[0], 26);
        chk("collide_no_long", nl[0], 0);
        clr_stats();
        btn_n[0] = 1'b0; run(21);
        btn_n[0] = 1'b1; run(15);
        chk("nocollide_long_time", tl[0], 26);
        chk("nocollide_rel_time", tr[0], 27);
    endtask

    task automatic test_independence();
        clr_stats();
        btn_n = 2'b10; run(2);
        btn_n = 2'b00; run(33);
        chk("indep_press0_time", tp[0], 6);
        chk("indep_press_gap", tp[1] - tp[0], 2);
        chk("indep_long_gap", tl[1] - tl[0], 2);
        chk("indep_no_overlap", overlap, 0);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({level_o, press_o, release_o, long_o} !== 8'h00)
            $display("FAIL midreset_async: got %h expected 00",
                     {level_o, press_o, release_o, long_o});
        else passed++;
        clr_stats();
        btn_n = 2'b11;
        run(3);
        rst = 1'b0;
        run(15);
        chk("midreset_no_release", nr[0] + nr[1] + np[0] + np[1], 0);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst    = 1'b1;
        btn_n  = 2'b11;
        clr_stats();
        test_reset();
        test_clean();
        test_bounce();
        test_short();
        test_collision();
        test_independence();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
